calibration_multi: RTL

Parametrised successor to the single-point colour calibration block. Accumulates raw RGB over NUM_REGIONS configurable square windows during one camera frame, averages each window, converts the averages to YUV and stores one result per region for readback. Sits between the camera pixel stream (row/col counters) and the colour-threshold logic that consumes calibrated Y/U/V references.

---
 rtl/calibration_multi.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/calibration_multi.sv
// ---------------------------------------------------------------------------
// calibration_multi
//
// Multi-region colour calibration. During one camera frame the raw RGB
// stream is summed inside NUM_REGIONS square windows (side 2^WIN_LOG2).
// After the frame-end pixel each window average is converted to YUV
// through a two-stage multiply / sum pipeline, one region per cycle.
// The results are stored per region for readback by the colour-threshold
// logic.
//
// Optional build macro: CAL_FRAME_AVG_EN
//   When defined, accumulation spans 4 consecutive frames. The
//   accumulators gain 2 bits and the averaging shift gains 2.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 one-cycle pulse, arms a run (ignored while busy)
//   pix_valid             raw_R/G/B, row, col valid this cycle
//   raw_R/raw_G/raw_B     8-bit pixel samples
//   row, col              current pixel coordinates
//   cfg_we/idx/row/col    window origin write (IDLE only)
//   rd_idx                region selected for readback
//   Y_out/U_out/V_out     registered YUV of region rd_idx (U/V signed)
//   busy                  high in ARM, ACCUM, CONVERT
//   done                  one-cycle pulse when the last region retires
//   Ctr                   completed-run count, saturating at 31
// ---------------------------------------------------------------------------
module calibration_multi #(
  parameter int NUM_REGIONS = 4,
  parameter int WIN_LOG2    = 2,
  parameter int COORD_W     = 13,
  parameter int FRAME_ROWS  = 480,
  parameter int FRAME_COLS  = 640
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               pix_valid,
  input  logic [7:0]         raw_R,
  input  logic [7:0]         raw_G,
  input  logic [7:0]         raw_B,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_idx,
  input  logic [COORD_W-1:0] cfg_row,
  input  logic [COORD_W-1:0] cfg_col,
  input  logic [2:0]         rd_idx,
  output logic [7:0]         Y_out,
  output logic signed [8:0]  U_out,
  output logic signed [8:0]  V_out,
  output logic               busy,
  output logic               done,
  output logic [4:0]         Ctr
);

`ifdef CAL_FRAME_AVG_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  localparam int ACC_W = 8 + 2 * WIN_LOG2 + EXTRA;
  localparam int SHIFT = 2 * WIN_LOG2 + EXTRA;

  // One extra bit so a window near the coordinate limit never wraps.
  localparam logic [COORD_W:0]   WIN_EXT  = (COORD_W + 1)'(1 << WIN_LOG2);
  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(FRAME_ROWS - 1);
  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(FRAME_COLS - 1);
  localparam logic [3:0]         NR4      = 4'(NUM_REGIONS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_ACCUM   = 2'd2,
    S_CONVERT = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [COORD_W-1:0] r_org_row [NUM_REGIONS];
  logic [COORD_W-1:0] r_org_col [NUM_REGIONS];
  logic [ACC_W-1:0]   r_acc_r   [NUM_REGIONS];
  logic [ACC_W-1:0]   r_acc_g   [NUM_REGIONS];
  logic [ACC_W-1:0]   r_acc_b   [NUM_REGIONS];
  logic [7:0]         r_res_y   [NUM_REGIONS];
  logic signed [8:0]  r_res_u   [NUM_REGIONS];
  logic signed [8:0]  r_res_v   [NUM_REGIONS];

  logic [COORD_W:0]     w_row_lim [NUM_REGIONS];
  logic [COORD_W:0]     w_col_lim [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] w_hit;

  logic w_frame_start;
  logic w_frame_end;
  logic w_last_frame;
  logic w_enter_arm;
  logic w_acc_en;
  logic w_last_retire;
  logic w_busy_nxt;
  logic w_done_nxt;

  logic       r_busy;
  logic       r_done;
  logic [4:0] r_ctr;

  // Conversion pipeline state
  logic [3:0]  r_iss_idx;
  logic        r_s1_vld;
  logic [3:0]  r_s1_idx;
  logic [15:0] r_p_ry, r_p_gy, r_p_by;
  logic [15:0] r_p_ru, r_p_gu, r_p_bu;
  logic [15:0] r_p_rv, r_p_gv, r_p_bv;
  logic        r_s2_vld;
  logic [3:0]  r_s2_idx;
  logic [7:0]  r_s2_y;
  logic signed [8:0] r_s2_u;
  logic signed [8:0] r_s2_v;

  logic [7:0]  w_avg_r, w_avg_g, w_avg_b;
  logic [17:0] w_y_sum;
  logic signed [17:0] w_u_sum;
  logic signed [17:0] w_v_sum;

  logic [7:0]        w_rd_y;
  logic signed [8:0] w_rd_u;
  logic signed [8:0] w_rd_v;

  logic [7:0]        r_y_out;
  logic signed [8:0] r_u_out;
  logic signed [8:0] r_v_out;

  assign w_frame_start = pix_valid && (row == {COORD_W{1'b0}}) && (col == {COORD_W{1'b0}});
  assign w_frame_end   = pix_valid && (row == ROW_LAST) && (col == COL_LAST);
  assign w_enter_arm   = (r_state == S_IDLE) && (w_next == S_ARM);
  assign w_acc_en      = ((r_state == S_ARM) && w_frame_start) || (r_state == S_ACCUM);
  assign w_last_retire = r_s2_vld && (r_s2_idx == (NR4 - 4'd1));

  // Window membership: origin <= coord < origin + side, on both axes.
  genvar gi;
  for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_hit
    assign w_row_lim[gi] = {1'b0, r_org_row[gi]} + WIN_EXT;
    assign w_col_lim[gi] = {1'b0, r_org_col[gi]} + WIN_EXT;
    assign w_hit[gi] = pix_valid
                       && (row >= r_org_row[gi]) && ({1'b0, row} < w_row_lim[gi])
                       && (col >= r_org_col[gi]) && ({1'b0, col} < w_col_lim[gi]);
  end

`ifdef CAL_FRAME_AVG_EN
  logic [1:0] r_frame;

  // Counts completed frames within a multi-frame accumulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame <= 2'd0;
    end else if (w_enter_arm) begin
      r_frame <= 2'd0;
    end else if ((r_state == S_ACCUM) && w_frame_end) begin
      r_frame <= r_frame + 2'd1;
    end else begin
      r_frame <= r_frame;
    end
  end

  assign w_last_frame = (r_frame == 2'd3);
`else
  assign w_last_frame = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_ARM;
        else       w_next = S_IDLE;
      end
      S_ARM: begin
        if (w_frame_start) w_next = S_ACCUM;
        else               w_next = S_ARM;
      end
      S_ACCUM: begin
        if (w_frame_end && w_last_frame) w_next = S_CONVERT;
        else                             w_next = S_ACCUM;
      end
      S_CONVERT: begin
        if (w_last_retire) w_next = S_IDLE;
        else               w_next = S_CONVERT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // FSM output logic, registered below.
  always_comb begin
    w_busy_nxt = (w_next != S_IDLE);
    w_done_nxt = (r_state == S_CONVERT) && w_last_retire;
  end

  // Registered status outputs and saturating run counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ctr  <= 5'd0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_done_nxt && (r_ctr != 5'd31)) r_ctr <= r_ctr + 5'd1;
      else                                r_ctr <= r_ctr;
    end
  end

  // Window origin registers; writable only while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        r_org_row[i] <= {COORD_W{1'b0}};
        r_org_col[i] <= {COORD_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (cfg_we && (r_state == S_IDLE) && (cfg_idx == 3'(i))) begin
          r_org_row[i] <= cfg_row;
          r_org_col[i] <= cfg_col;
        end else begin
          r_org_row[i] <= r_org_row[i];
          r_org_col[i] <= r_org_col[i];
        end
      end
    end
  end

  // Per-region RGB accumulators; cleared when a run is armed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        r_acc_r[i] <= {ACC_W{1'b0}};
        r_acc_g[i] <= {ACC_W{1'b0}};
        r_acc_b[i] <= {ACC_W{1'b0}};
      end
    end else if (w_enter_arm) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        r_acc_r[i] <= {ACC_W{1'b0}};
        r_acc_g[i] <= {ACC_W{1'b0}};
        r_acc_b[i] <= {ACC_W{1'b0}};
      end
    end else if (w_acc_en) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (w_hit[i]) begin
          r_acc_r[i] <= r_acc_r[i] + ACC_W'(raw_R);
          r_acc_g[i] <= r_acc_g[i] + ACC_W'(raw_G);
          r_acc_b[i] <= r_acc_b[i] + ACC_W'(raw_B);
        end else begin
          r_acc_r[i] <= r_acc_r[i];
          r_acc_g[i] <= r_acc_g[i];
          r_acc_b[i] <= r_acc_b[i];
        end
      end
    end else begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        r_acc_r[i] <= r_acc_r[i];
        r_acc_g[i] <= r_acc_g[i];
        r_acc_b[i] <= r_acc_b[i];
      end
    end
  end

  // Average of the region being issued; the divisor is the full window
  // area even when the window was clipped by the frame edge.
  always_comb begin
    w_avg_r = 8'd0;
    w_avg_g = 8'd0;
    w_avg_b = 8'd0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      w_avg_r = (r_iss_idx == 4'(i)) ? 8'(r_acc_r[i] >> SHIFT) : w_avg_r;
      w_avg_g = (r_iss_idx == 4'(i)) ? 8'(r_acc_g[i] >> SHIFT) : w_avg_g;
      w_avg_b = (r_iss_idx == 4'(i)) ? 8'(r_acc_b[i] >> SHIFT) : w_avg_b;
    end
  end

  // Issue counter: walks regions 0..NUM_REGIONS-1 during CONVERT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_iss_idx <= 4'd0;
    end else if (r_state != S_CONVERT) begin
      r_iss_idx <= 4'd0;
    end else if (r_iss_idx < NR4) begin
      r_iss_idx <= r_iss_idx + 4'd1;
    end else begin
      r_iss_idx <= r_iss_idx;
    end
  end

  // Stage 1: coefficient magnitudes; signs are applied in stage 2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_vld <= 1'b0;
      r_s1_idx <= 4'd0;
      r_p_ry <= 16'd0; r_p_gy <= 16'd0; r_p_by <= 16'd0;
      r_p_ru <= 16'd0; r_p_gu <= 16'd0; r_p_bu <= 16'd0;
      r_p_rv <= 16'd0; r_p_gv <= 16'd0; r_p_bv <= 16'd0;
    end else if ((r_state == S_CONVERT) && (r_iss_idx < NR4)) begin
      r_s1_vld <= 1'b1;
      r_s1_idx <= r_iss_idx;
      r_p_ry <= 16'(w_avg_r) * 16'd77;
      r_p_gy <= 16'(w_avg_g) * 16'd150;
      r_p_by <= 16'(w_avg_b) * 16'd29;
      r_p_ru <= 16'(w_avg_r) * 16'd43;
      r_p_gu <= 16'(w_avg_g) * 16'd85;
      r_p_bu <= 16'(w_avg_b) * 16'd128;
      r_p_rv <= 16'(w_avg_r) * 16'd128;
      r_p_gv <= 16'(w_avg_g) * 16'd107;
      r_p_bv <= 16'(w_avg_b) * 16'd21;
    end else begin
      r_s1_vld <= 1'b0;
      r_s1_idx <= r_s1_idx;
      r_p_ry <= r_p_ry; r_p_gy <= r_p_gy; r_p_by <= r_p_by;
      r_p_ru <= r_p_ru; r_p_gu <= r_p_gu; r_p_bu <= r_p_bu;
      r_p_rv <= r_p_rv; r_p_gv <= r_p_gv; r_p_bv <= r_p_bv;
    end
  end

  assign w_y_sum = {2'b00, r_p_ry} + {2'b00, r_p_gy} + {2'b00, r_p_by};
  assign w_u_sum = $signed({2'b00, r_p_bu}) - $signed({2'b00, r_p_ru}) - $signed({2'b00, r_p_gu});
  assign w_v_sum = $signed({2'b00, r_p_rv}) - $signed({2'b00, r_p_gv}) - $signed({2'b00, r_p_bv});

  // Stage 2: sum and scale by 1/256; arithmetic shift floors U and V.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_vld <= 1'b0;
      r_s2_idx <= 4'd0;
      r_s2_y   <= 8'd0;
      r_s2_u   <= 9'sd0;
      r_s2_v   <= 9'sd0;
    end else begin
      r_s2_vld <= r_s1_vld;
      r_s2_idx <= r_s1_idx;
      r_s2_y   <= 8'(w_y_sum >> 8);
      r_s2_u   <= 9'(w_u_sum >>> 8);
      r_s2_v   <= 9'(w_v_sum >>> 8);
    end
  end

  // Result store: a region is overwritten only when it retires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        r_res_y[i] <= 8'd0;
        r_res_u[i] <= 9'sd0;
        r_res_v[i] <= 9'sd0;
      end
    end else begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (r_s2_vld && (r_s2_idx == 4'(i))) begin
          r_res_y[i] <= r_s2_y;
          r_res_u[i] <= r_s2_u;
          r_res_v[i] <= r_s2_v;
        end else begin
          r_res_y[i] <= r_res_y[i];
          r_res_u[i] <= r_res_u[i];
          r_res_v[i] <= r_res_v[i];
        end
      end
    end
  end

  // Readback select; indices beyond the configured regions read as zero.
  always_comb begin
    w_rd_y = 8'd0;
    w_rd_u = 9'sd0;
    w_rd_v = 9'sd0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      w_rd_y = (rd_idx == 3'(i)) ? r_res_y[i] : w_rd_y;
      w_rd_u = (rd_idx == 3'(i)) ? r_res_u[i] : w_rd_u;
      w_rd_v = (rd_idx == 3'(i)) ? r_res_v[i] : w_rd_v;
    end
  end

  // Registered readback outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_y_out <= 8'd0;
      r_u_out <= 9'sd0;
      r_v_out <= 9'sd0;
    end else begin
      r_y_out <= w_rd_y;
      r_u_out <= w_rd_u;
      r_v_out <= w_rd_v;
    end
  end

  assign Y_out = r_y_out;
  assign U_out = r_u_out;
  assign V_out = r_v_out;
  assign busy  = r_busy;
  assign done  = r_done;
  assign Ctr   = r_ctr;

endmodule
